// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: opcode and FSM state.
package mips_cpu_muldiv_pkg;

  // Codes 6 and 7 are unused and act as no-ops.
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_step.sv
// One combinational iteration of the unsigned core.
//   Mul: acc = {upper, multiplier}; add the multiplicand to the upper half when
//        the multiplier LSB is set, then shift the whole accumulator right.
//   Div: acc = {remainder, dividend/quotient}; shift left, trial-subtract the
//        divisor, keep the old value (restore) when it does not fit, and shift
//        the quotient bit into the bottom.
module mips_cpu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;

  // Compute both step flavours and select the one for the current operation.
  always_comb begin
    // Carry out of the add lands in the top bit after the right shift.
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Remainder shifted left with the next dividend bit appended.
    trial   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    fits    = (trial >= {1'b0, opnd_i});
    // The true difference is below the divisor, so WIDTH bits are enough.
    rem_sub = trial[WIDTH-1:0] - opnd_i;
    if (div_mode) begin
      if (fits) acc_o = {rem_sub, acc_i[WIDTH-2:0], 1'b1};
      else      acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign fix-up happens in FIX.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32  // even, at least 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  md_state_t          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic               is_div_q, is_div_d;
  logic               done_q, done_d;

  logic               accept, signed_op, a_neg, b_neg, last_step;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;

  assign accept    = (state_q == IDLE) && start;
  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg     = signed_op && a[WIDTH-1];
  assign b_neg     = signed_op && b[WIDTH-1];
  // The most-negative value maps onto itself, which is its correct unsigned magnitude.
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign last_step = (cnt_q == LAST_STEP);

  // Signed results: product/quotient flip when signs differ, remainder follows the dividend.
  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quot = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  // FSM next state: IDLE -> MUL/DIV on an accepted arithmetic op, WIDTH steps, then FIX.
  always_comb begin
    // NOTE: every combinational output is given a default before any branch so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == MD_MULT || op == MD_MULTU)    state_d = MUL;
          else if (op == MD_DIV || op == MD_DIVU) state_d = DIV;
        end
      end
      MUL, DIV: if (last_step) state_d = FIX;
      FIX:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath next state: operand latch on accept, one core step per cycle, result write in FIX.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    if (accept) begin
      case (op)
        MD_MULT, MD_MULTU: begin
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, b_mag};
          opnd_d    = a_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = 1'b0;
          div0_d    = 1'b0;
          is_div_d  = 1'b0;
        end
        MD_DIV, MD_DIVU: begin
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, a_mag};
          opnd_d    = b_mag;
          a_raw_d   = a;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (b == '0);
          is_div_d  = 1'b1;
        end
        MD_MTHI: hi_d = a;
        MD_MTLO: lo_d = a;
        default: ;
      endcase
    end else if (state_q == MUL || state_q == DIV) begin
      acc_d = step_acc;
      cnt_d = cnt_q + CW'(1);
    end else if (state_q == FIX) begin
      done_d = 1'b1;
      if (!is_div_q) begin
        {hi_d, lo_d} = prod;
      end else if (div0_q) begin
        // Divide by zero bypasses sign correction entirely.
        lo_d = '1;
        hi_d = a_raw_q;
      end else begin
        lo_d = quot;
        hi_d = rem;
      end
    end
  end

  // FSM state register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and HI/LO registers; reset discards any partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // FIX is still part of the operation, so busy covers it; done follows one edge later.
  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Bench for mips_cpu_muldiv: directed scenarios plus randomized ops checked
// against an arithmetic reference model, on a 32-bit and an 8-bit instance.
module tb_mips_cpu_muldiv;
  import mips_cpu_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic        start32, busy32, done32;
  muldiv_op_t  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        start8, busy8, done8;
  muldiv_op_t  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  always #5 clk = ~clk;

  mips_cpu_muldiv #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mips_cpu_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void ref_model(input int op, input int w,
                                    input longint unsigned a, input longint unsigned b,
                                    output longint unsigned hi, output longint unsigned lo);
    longint unsigned mask, p;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    hi = 64'd0;
    lo = 64'd0;
    case (op)
      0: begin p = sa * sb; hi = (p >> w) & mask; lo = p & mask; end
      1: begin p = a * b;   hi = (p >> w) & mask; lo = p & mask; end
      2: begin
        if (b == 64'd0) begin lo = mask; hi = a; end
        else begin q = sa / sb; r = sa % sb; lo = q & mask; hi = r & mask; end
      end
      3: begin
        if (b == 64'd0) begin lo = mask; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Issue one op on the 32-bit unit and wait (bounded) for done; cycles counts
  // negedges after the acceptance cycle, so a correct unit gives WIDTH+1.
  task automatic run32(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                       output int cycles);
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    @(negedge clk);
    start32 = 1'b0;
    cycles = 0;
    while (done32 !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run8(input muldiv_op_t o, input logic [7:0] x, input logic [7:0] y,
                      output int cycles);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    while (done8 !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start32 = 1'b0; op32 = MD_MULT; a32 = '0; b32 = '0;
    start8 = 1'b0;  op8 = MD_MULT;  a8 = '0;  b8 = '0;
    @(negedge clk);
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy32); end
    checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done32); end
    checks++; if (hi32 !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi32); end
    checks++; if (lo32 !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo32); end
    checks++; if ({hi8, lo8} !== 16'h0) begin errors++; $display("FAIL reset_hilo8: got %h expected 0", {hi8, lo8}); end
    reset = 1'b0;
  endtask

  task automatic test_mult_signed();
    int cyc;
    run32(MD_MULT, 32'hFFFF_FFFF, 32'd2, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
    checks++; if (hi32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", hi32); end
    checks++; if (lo32 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo: got %h expected fffffffe", lo32); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL mult_busy_in_done: got %b expected 0", busy32); end
    @(negedge clk);
    checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b expected 0", done32); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run32(MD_MULTU, 32'hFFFF_FFFF, 32'd2, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL multu_latency: got %0d expected 33", cyc); end
    checks++; if (hi32 !== 32'h1) begin errors++; $display("FAIL multu_hi: got %h expected 00000001", hi32); end
    checks++; if (lo32 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h expected fffffffe", lo32); end
    // Still in the done cycle: issue the next op right away.
    start32 = 1'b1; op32 = MD_DIVU; a32 = 32'd100; b32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b expected 1", busy32); end
    cyc = 0;
    while (done32 !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", cyc); end
    checks++; if (lo32 !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected 0000000e", lo32); end
    checks++; if (hi32 !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected 00000002", hi32); end
  endtask

  task automatic test_div_corners();
    int cyc;
    run32(MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (lo32 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo32); end
    checks++; if (hi32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi32); end
    run32(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (lo32 !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", lo32); end
    checks++; if (hi32 !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 00000000", hi32); end
    run32(MD_DIVU, 32'd7, 32'd0, cyc);
    checks++; if (lo32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_zero_lo: got %h expected ffffffff", lo32); end
    checks++; if (hi32 !== 32'd7) begin errors++; $display("FAIL divu_zero_hi: got %h expected 00000007", hi32); end
    run32(MD_DIV, 32'hFFFF_FFF9, 32'd0, cyc);
    checks++; if (lo32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_zero_lo: got %h expected ffffffff", lo32); end
    checks++; if (hi32 !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div_zero_hi: got %h expected fffffff9", hi32); end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start32 = 1'b1; op32 = MD_MTHI; a32 = 32'h1234;
    @(negedge clk);
    checks++; if (hi32 !== 32'h1234) begin errors++; $display("FAIL mthi: got %h expected 00001234", hi32); end
    checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b expected 0", busy32); end
    op32 = MD_MTLO; a32 = 32'h5678;
    @(negedge clk);
    start32 = 1'b0;
    checks++; if (lo32 !== 32'h5678) begin errors++; $display("FAIL mtlo: got %h expected 00005678", lo32); end
    checks++; if (hi32 !== 32'h1234) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected 00001234", hi32); end
    checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL mtlo_busy_done: got %b expected 00", {busy32, done32}); end
  endtask

  task automatic test_noop_codes();
    @(negedge clk);
    start32 = 1'b1; op32 = MD_MTHI; a32 = 32'hA5A5_A5A5;
    @(negedge clk);
    op32 = MD_MTLO; a32 = 32'h5A5A_5A5A;
    for (int c = 6; c <= 7; c++) begin
      @(negedge clk);
      op32 = muldiv_op_t'(3'(c)); a32 = $urandom(); b32 = $urandom();
      @(negedge clk);
      checks++; if ({hi32, lo32} !== 64'hA5A5_A5A5_5A5A_5A5A) begin errors++; $display("FAIL noop_%0d_hilo: got %h expected a5a5a5a55a5a5a5a", c, {hi32, lo32}); end
      checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL noop_%0d_busy_done: got %b expected 00", c, {busy32, done32}); end
    end
    start32 = 1'b0;
  endtask

  task automatic test_start_ignored();
    int cyc;
    @(negedge clk);
    start32 = 1'b1; op32 = MD_MTLO; a32 = 32'h1111;
    @(negedge clk);
    op32 = MD_MULT; a32 = 32'hFFFF_FFFA; b32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    start32 = 1'b1; op32 = MD_MTLO; a32 = 32'hDEAD_BEEF; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    checks++; if (lo32 !== 32'h1111) begin errors++; $display("FAIL ignored_mtlo: got %h expected 00001111", lo32); end
    checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL ignored_busy: got %b expected 1", busy32); end
    cyc = 0;
    while (done32 !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (cyc !== 27) begin errors++; $display("FAIL ignored_latency: got %0d expected 27", cyc); end
    checks++; if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFD6) begin errors++; $display("FAIL ignored_product: got %h expected ffffffffffffffd6", {hi32, lo32}); end
  endtask

  task automatic test_reset_mid_div();
    int cyc;
    @(negedge clk);
    start32 = 1'b1; op32 = MD_MTHI; a32 = 32'hFFFF;
    @(negedge clk);
    op32 = MD_DIV; a32 = 32'h1234_5678; b32 = 32'd3;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({busy32, done32} !== 2'b00) begin errors++; $display("FAIL async_reset_busy_done: got %b expected 00", {busy32, done32}); end
    checks++; if ({hi32, lo32} !== 64'h0) begin errors++; $display("FAIL async_reset_hilo: got %h expected 0", {hi32, lo32}); end
    @(negedge clk);
    reset = 1'b0;
    run32(MD_MULTU, 32'd3, 32'd5, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL post_reset_latency: got %0d expected 33", cyc); end
    checks++; if ({hi32, lo32} !== 64'd15) begin errors++; $display("FAIL post_reset_multu: got %h expected 000000000000000f", {hi32, lo32}); end
  endtask

  task automatic test_random32();
    int cyc, sel;
    logic [2:0] ob;
    logic [31:0] x, y;
    longint unsigned eh, el;
    for (int i = 0; i < 30; i++) begin
      ob = 3'($urandom_range(0, 3));
      x = $urandom();
      y = $urandom();
      sel = $urandom_range(0, 7);
      if (sel == 0) y = 32'h0;
      else if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      else if (sel == 2) y = 32'($urandom_range(1, 15));
      ref_model(int'(ob), 32, 64'(x), 64'(y), eh, el);
      run32(muldiv_op_t'(ob), x, y, cyc);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL rnd32_%0d_latency: got %0d expected 33", i, cyc); end
      checks++; if (hi32 !== 32'(eh)) begin errors++; $display("FAIL rnd32_%0d_hi op=%0d a=%h b=%h: got %h expected %h", i, ob, x, y, hi32, 32'(eh)); end
      checks++; if (lo32 !== 32'(el)) begin errors++; $display("FAIL rnd32_%0d_lo op=%0d a=%h b=%h: got %h expected %h", i, ob, x, y, lo32, 32'(el)); end
      @(negedge clk);
      checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL rnd32_%0d_done_pulse: got %b expected 0", i, done32); end
    end
  endtask

  task automatic test_width8();
    int cyc;
    logic [2:0] ob;
    logic [7:0] x, y;
    longint unsigned eh, el;
    run8(MD_MULT, 8'hFD, 8'h05, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL w8_latency: got %0d expected 9", cyc); end
    checks++; if ({hi8, lo8} !== 16'hFFF1) begin errors++; $display("FAIL w8_mult: got %h expected fff1", {hi8, lo8}); end
    for (int i = 0; i < 25; i++) begin
      ob = 3'($urandom_range(0, 3));
      x = 8'($urandom());
      y = (i % 6 == 0) ? 8'h00 : 8'($urandom());
      if (i % 7 == 3) begin x = 8'h80; y = 8'hFF; end
      ref_model(int'(ob), 8, 64'(x), 64'(y), eh, el);
      run8(muldiv_op_t'(ob), x, y, cyc);
      checks++; if (cyc !== 9) begin errors++; $display("FAIL rnd8_%0d_latency: got %0d expected 9", i, cyc); end
      checks++; if ({hi8, lo8} !== {8'(eh), 8'(el)}) begin errors++; $display("FAIL rnd8_%0d op=%0d a=%h b=%h: got %h expected %h", i, ob, x, y, {hi8, lo8}, {8'(eh), 8'(el)}); end
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_back_to_back();
    test_div_corners();
    test_mthi_mtlo();
    test_noop_codes();
    test_start_ignored();
    test_reset_mid_div();
    test_random32();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
